// File: rtl/ransac_ctrl_pkg.sv
// Job controller state encoding and result status bundle.
// Imported by ransac_job_controller.
package ransac_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_ARM,
        S_WAIT_CAN,
        S_START,
        S_RUN,
        S_RESULT
    } ctrl_state_t;

    typedef struct packed {
        logic timeout;
        logic truncated;
    } result_status_t;

endpackage

// File: rtl/ransac_fixed.sv
// Fixed-point data types shared by the RANSAC core and its controller.
// Q16.16 signed scalars, 3-D points and plane coefficients.
package ransac_fixed;

    typedef logic signed [31:0] fixed_t;

    typedef struct packed {
        fixed_t x;
        fixed_t y;
        fixed_t z;
    } point_t;

    typedef struct packed {
        fixed_t a;
        fixed_t b;
        fixed_t c;
        fixed_t d;
    } plane_t;

endpackage

// File: rtl/ransac_point_buffer.sv
// Point cloud store: 1W/1R RAM followed by a read pipeline of
// mem_read_latency stages. Ports: wr_en/wr_addr/wr_data write side,
// rd_en/rd_addr read request, rd_data/rd_valid delayed response.
module ransac_point_buffer
    import ransac_fixed::*;
#(
    parameter int point_addr_width = 9,
    parameter int mem_read_latency = 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic [point_addr_width-1:0] wr_addr,
    input  point_t                      wr_data,
    input  logic                        rd_en,
    input  logic [point_addr_width-1:0] rd_addr,
    output point_t                      rd_data,
    output logic                        rd_valid
);

    point_t mem [2**point_addr_width];

    point_t                      data_pipe [mem_read_latency];
    logic [mem_read_latency-1:0] vld_pipe;

    // Storage is never cleared; only the response pipeline is reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_pipe <= '0;
            for (int i = 0; i < mem_read_latency; i++) begin
                data_pipe[i] <= '0;
            end
        end else begin
            vld_pipe[0] <= rd_en;
            if (rd_en) begin
                data_pipe[0] <= mem[rd_addr];
            end
            for (int i = 1; i < mem_read_latency; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                data_pipe[i] <= data_pipe[i-1];
            end
        end
    end

    assign rd_data  = data_pipe[mem_read_latency-1];
    assign rd_valid = vld_pipe[mem_read_latency-1];

endmodule

// File: rtl/ransac_job_controller.sv
// Sequencer between a host point stream and one ransac_logic core.
// Ports: load_* host stream in, result_* plane out (valid/ready),
// core_* reset/config/start, point read service and done/plane return.
module ransac_job_controller
    import ransac_fixed::*;
    import ransac_ctrl_pkg::*;
#(
    parameter int point_addr_width  = 9,
    parameter int mem_read_latency  = 1,
    parameter int core_reset_cycles = 2,
    parameter int watchdog_cycles   = 2**24
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        load_valid,
    output logic                        load_ready,
    input  point_t                      load_point,
    input  logic                        load_last,
    input  logic [31:0]                 job_iterations,
    input  fixed_t                      job_threshold,
    output logic                        result_valid,
    input  logic                        result_ready,
    output plane_t                      result_plane,
    output logic                        result_timeout,
    output logic                        result_truncated,
    output logic                        busy,
    output logic                        core_reset,
    output point_t                      core_point,
    input  logic [point_addr_width-1:0] core_point_addr,
    input  logic                        core_point_addr_valid,
    output logic                        core_point_data_valid,
    output logic [point_addr_width-1:0] core_point_count,
    output logic [31:0]                 core_iterations,
    output fixed_t                      core_threshold,
    output logic                        core_calculation_start,
    input  logic                        core_calculation_can_start,
    input  logic                        core_calculation_done,
    input  plane_t                      core_plane
);

    localparam int arm_w = $clog2(core_reset_cycles + 1);
    localparam logic [arm_w-1:0] arm_last = arm_w'(core_reset_cycles - 1);
    localparam logic [31:0] wd_last = 32'(watchdog_cycles - 1);
    localparam logic [point_addr_width-1:0] idx_last = '1;

    ctrl_state_t state, state_d;

    logic [point_addr_width-1:0] wr_ptr;
    logic [arm_w-1:0]            arm_cnt;
    logic [31:0]                 watchdog;
    logic                        done_q;
    result_status_t              status;

    logic beat;
    logic done_rise;
    logic wd_expire;
    logic wr_en;
    logic rd_en;
    logic [point_addr_width-1:0] wr_addr;

    assign beat      = load_valid & load_ready;
    assign done_rise = core_calculation_done & ~done_q;
    assign wd_expire = (watchdog == wd_last);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d                = state;
        load_ready             = 1'b0;
        busy                   = 1'b1;
        result_valid           = 1'b0;
        core_calculation_start = 1'b0;
        unique case (state)
            S_IDLE: begin
                load_ready = 1'b1;
                busy       = 1'b0;
                if (beat) begin
                    state_d = load_last ? S_ARM : S_LOAD;
                end
            end
            S_LOAD: begin
                load_ready = 1'b1;
                if (beat) begin
                    if (load_last) begin
                        state_d = S_ARM;
                    end else if (wr_ptr == idx_last) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                load_ready = 1'b1;
                if (beat && load_last) begin
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                if (core_iterations == '0) begin
                    state_d = S_RESULT;
                end else if (arm_cnt == arm_last) begin
                    state_d = S_WAIT_CAN;
                end
            end
            S_WAIT_CAN: begin
                if (core_calculation_can_start) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                core_calculation_start = 1'b1;
                state_d                = S_RUN;
            end
            S_RUN: begin
                if (done_rise || wd_expire) begin
                    state_d = S_RESULT;
                end
            end
            S_RESULT: begin
                result_valid = 1'b1;
                if (result_ready) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr           <= '0;
            arm_cnt          <= '0;
            watchdog         <= '0;
            done_q           <= 1'b0;
            status           <= '0;
            result_plane     <= '0;
            core_reset       <= 1'b1;
            core_point_count <= '0;
            core_iterations  <= '0;
            core_threshold   <= '0;
        end else begin
            done_q <= core_calculation_done;
            if (state != S_ARM) begin
                arm_cnt <= '0;
            end
            unique case (state)
                S_IDLE: begin
                    core_reset <= 1'b1;
                    if (beat) begin
                        core_iterations  <= job_iterations;
                        core_threshold   <= job_threshold;
                        status           <= '0;
                        wr_ptr           <= point_addr_width'(1);
                        core_point_count <= '0;
                    end
                end
                S_LOAD: begin
                    if (beat) begin
                        wr_ptr           <= wr_ptr + 1'b1;
                        core_point_count <= wr_ptr;
                        if (!load_last && wr_ptr == idx_last) begin
                            status.truncated <= 1'b1;
                        end
                    end
                end
                S_ARM: begin
                    arm_cnt <= arm_cnt + 1'b1;
                    // A zero-iteration job never releases the core.
                    if (core_iterations == '0) begin
                        result_plane <= '0;
                    end else if (arm_cnt == arm_last) begin
                        core_reset <= 1'b0;
                    end
                end
                S_START: begin
                    watchdog <= '0;
                end
                S_RUN: begin
                    watchdog <= watchdog + 1'b1;
                    // Completion takes priority over a coincident expiry.
                    if (done_rise) begin
                        result_plane <= core_plane;
                    end else if (wd_expire) begin
                        status.timeout <= 1'b1;
                        result_plane   <= '0;
                        core_reset     <= 1'b1;
                    end
                end
                S_RESULT: begin
                    if (result_ready) begin
                        core_reset <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign result_timeout   = status.timeout;
    assign result_truncated = status.truncated;

    assign wr_en   = beat & ((state == S_IDLE) | (state == S_LOAD));
    assign wr_addr = (state == S_IDLE) ? '0 : wr_ptr;
    assign rd_en   = core_point_addr_valid & (state == S_RUN);

    ransac_point_buffer #(
        .point_addr_width (point_addr_width),
        .mem_read_latency (mem_read_latency)
    ) u_buffer (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (load_point),
        .rd_en    (rd_en),
        .rd_addr  (core_point_addr),
        .rd_data  (core_point),
        .rd_valid (core_point_data_valid)
    );

endmodule
